// File: rtl/four_sixteen_decoder.sv
// ---------------------------------------------------------------------------
// four_sixteen_decoder
//
// Ping-pong 4-bit counter (0..15..0, end values shown for a single step)
// advanced through a DIV-cycle prescaler, followed by a combinational
// 4-to-16 LED pattern decoder.
//
// Parameters
//   DIV    enabled Clk cycles per counter step, legal range 1..65535
//
// Ports
//   Clk    single clock, all state updates on the rising edge
//   reset  synchronous active-low reset (count=0, dir=UP, prescaler=0)
//   en     counter advance enable
//   start  display enable
//   idle   idle-pattern request, overrides start and mode
//   mode   pattern select: 00 blank, 01 one-hot, 10 bar, 11 inverted one-hot
//   count  current counter value (registered)
//   LED    LED drive, combinational from count, mode, start and idle
// ---------------------------------------------------------------------------
module four_sixteen_decoder #(
    parameter int unsigned DIV = 1
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        en,
    input  logic        start,
    input  logic        idle,
    input  logic [1:0]  mode,
    output logic [3:0]  count,
    output logic [15:0] LED
);

    // Last prescaler value before a step; DIV=1 makes every enabled cycle a step.
    localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t        dir_r;
    dir_t        dir_nxt_s;
    logic [3:0]  count_r;
    logic [3:0]  count_nxt_s;
    logic [15:0] presc_r;
    logic [15:0] presc_nxt_s;
    logic        step_s;
    logic [15:0] led_s;

    // Thermometer pattern: every position up to and including cnt is lit.
    function automatic logic [15:0] bar_pattern(input logic [3:0] cnt);
        logic [15:0] bar;
        bar = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            bar[k] = (4'(k) <= cnt);
        end
        return bar;
    endfunction

    // Single-position pattern: only position cnt is lit.
    function automatic logic [15:0] onehot_pattern(input logic [3:0] cnt);
        return 16'h0001 << cnt;
    endfunction

    // Prescaler: counts enabled cycles and flags the step on the last one.
    always_comb begin
        step_s      = 1'b0;
        presc_nxt_s = presc_r;
        if (en) begin
            if (presc_r >= PRESC_LAST) begin
                step_s      = 1'b1;
                presc_nxt_s = 16'h0000;
            end else begin
                presc_nxt_s = presc_r + 16'h0001;
            end
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Ping-pong next state: bounce at the ends so 0 and 15 last one step each.
    always_comb begin
        count_nxt_s = count_r;
        dir_nxt_s   = dir_r;
        if (step_s) begin
            case (dir_r)
                DIR_UP: begin
                    if (count_r == 4'd15) begin
                        count_nxt_s = 4'd14;
                        dir_nxt_s   = DIR_DOWN;
                    end else begin
                        count_nxt_s = count_r + 4'd1;
                    end
                end
                DIR_DOWN: begin
                    if (count_r == 4'd0) begin
                        count_nxt_s = 4'd1;
                        dir_nxt_s   = DIR_UP;
                    end else begin
                        count_nxt_s = count_r - 4'd1;
                    end
                end
                default: begin
                    count_nxt_s = 4'd0;
                    dir_nxt_s   = DIR_UP;
                end
            endcase
        end else begin
            count_nxt_s = count_r;
            dir_nxt_s   = dir_r;
        end
    end

    // State register with synchronous active-low reset overriding en.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            count_r <= 4'd0;
            dir_r   <= DIR_UP;
            presc_r <= 16'h0000;
        end else begin
            count_r <= count_nxt_s;
            dir_r   <= dir_nxt_s;
            presc_r <= presc_nxt_s;
        end
    end

    // LED decoder: idle beats start, start beats mode; no register stage.
    always_comb begin
        led_s = 16'h0000;
        if (idle) begin
            led_s = 16'h8001;
        end else if (!start) begin
            led_s = 16'h0000;
        end else begin
            case (mode)
                2'b00:   led_s = 16'h0000;
                2'b01:   led_s = onehot_pattern(count_r);
                2'b10:   led_s = bar_pattern(count_r);
                2'b11:   led_s = ~onehot_pattern(count_r);
                default: led_s = 16'h0000;
            endcase
        end
    end

    assign count = count_r;
    assign LED   = led_s;

endmodule

// File: tb/tb_four_sixteen_decoder.sv
module tb_four_sixteen_decoder;

    logic        Clk = 1'b0;
    logic        reset;
    logic        en;
    logic        start;
    logic        idle;
    logic [1:0]  mode;
    logic [3:0]  count;
    logic [15:0] LED;

    logic        reset4;
    logic        en4;
    logic [3:0]  count4;
    logic [15:0] led4;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0]  target;
        logic        idle;
        logic        start;
        logic [1:0]  mode;
        logic [15:0] led;
    } led_vec_t;

    led_vec_t vecs [12];

    four_sixteen_decoder #(.DIV(1)) dut (
        .Clk(Clk), .reset(reset), .en(en), .start(start), .idle(idle),
        .mode(mode), .count(count), .LED(LED)
    );

    four_sixteen_decoder #(.DIV(4)) dut4 (
        .Clk(Clk), .reset(reset4), .en(en4), .start(start), .idle(idle),
        .mode(mode), .count(count4), .LED(led4)
    );

    always #5 Clk = ~Clk;

    // Expected counter value after k steps from reset.
    function automatic logic [15:0] pingpong(input int k);
        int m;
        m = k % 30;
        if (m <= 15) return 16'(m);
        else return 16'(30 - m);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One rising edge, then return on the following falling edge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int e;
        int i;

        vecs[0]  = '{4'd5,  1'b0, 1'b1, 2'b10, 16'h003F};
        vecs[1]  = '{4'd15, 1'b0, 1'b1, 2'b10, 16'hFFFF};
        vecs[2]  = '{4'd0,  1'b0, 1'b1, 2'b10, 16'h0001};
        vecs[3]  = '{4'd3,  1'b0, 1'b1, 2'b11, 16'hFFF7};
        vecs[4]  = '{4'd3,  1'b1, 1'b1, 2'b11, 16'h8001};
        vecs[5]  = '{4'd3,  1'b1, 1'b0, 2'b01, 16'h8001};
        vecs[6]  = '{4'd7,  1'b0, 1'b0, 2'b11, 16'h0000};
        vecs[7]  = '{4'd9,  1'b0, 1'b1, 2'b00, 16'h0000};
        vecs[8]  = '{4'd9,  1'b0, 1'b1, 2'b01, 16'h0200};
        vecs[9]  = '{4'd12, 1'b0, 1'b1, 2'b11, 16'hEFFF};
        vecs[10] = '{4'd1,  1'b0, 1'b1, 2'b10, 16'h0003};
        vecs[11] = '{4'd10, 1'b0, 1'b1, 2'b01, 16'h0400};

        reset  = 1'b0;
        en     = 1'b1;
        start  = 1'b0;
        idle   = 1'b0;
        mode   = 2'b01;
        reset4 = 1'b0;
        en4    = 1'b0;
        @(negedge Clk);

        // Reset held 4 cycles with en=1 and start=0, then free run.
        for (int k = 0; k < 4; k++) begin
            tick();
            check("reset_count", 16'(count), 16'h0000);
            check("reset_led_blank", LED, 16'h0000);
        end
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("run_count", 16'(count), pingpong(k));
            check("run_led_blank", LED, 16'h0000);
        end

        // One-hot walk from 0 up to 15 and back down.
        start = 1'b1;
        mode  = 2'b01;
        reset = 1'b0;
        tick();
        check("reset_led_onehot", LED, 16'h0001);
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("onehot_led", LED, 16'h0001 << pingpong(k));
        end

        // Decoder table at frozen counter values.
        for (int v = 0; v < 12; v++) begin
            en    = 1'b1;
            idle  = 1'b0;
            start = 1'b1;
            do_reset();
            for (int k = 0; k < int'(vecs[v].target); k++) tick();
            en    = 1'b0;
            idle  = vecs[v].idle;
            start = vecs[v].start;
            mode  = vecs[v].mode;
            #1;
            check("table_count", 16'(count), 16'(vecs[v].target));
            check("table_led", LED, vecs[v].led);
        end

        // Idle overrides then releases to the inverted one-hot pattern at count 3.
        idle  = 1'b0;
        start = 1'b1;
        mode  = 2'b11;
        en    = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) tick();
        en = 1'b0;
        idle = 1'b1;
        tick();
        check("idle_led", LED, 16'h8001);
        idle = 1'b0;
        #1;
        check("idle_release_led", LED, 16'hFFF7);
        check("idle_count_hold", 16'(count), 16'h0003);

        // Up to 15, down to 7, hold 3 cycles, continue across the 0 bounce;
        // mode changes every cycle and must not disturb the counter.
        en = 1'b1;
        do_reset();
        s = 0;
        for (int k = 0; k < 23; k++) begin
            mode = 2'(k);
            tick();
            s++;
            check("pp_count", 16'(count), pingpong(s));
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mode = 2'(k + 1);
            tick();
            check("hold_count", 16'(count), 16'h0007);
        end
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            mode = 2'(k + 2);
            tick();
            s++;
            check("resume_count", 16'(count), pingpong(s));
        end

        // Mid-sequence reset with en held high restarts from 0 counting up.
        reset = 1'b0;
        tick();
        check("midreset_count", 16'(count), 16'h0000);
        reset = 1'b1;
        tick();
        check("after_midreset_1", 16'(count), 16'h0001);
        tick();
        check("after_midreset_2", 16'(count), 16'h0002);

        // DIV=4 instance: one step per 4 enabled cycles, en gaps hold the prescaler.
        en4 = 1'b1;
        reset4 = 1'b0;
        tick();
        check("div4_reset_count", 16'(count4), 16'h0000);
        reset4 = 1'b1;
        e = 0;
        i = 0;
        while (e < 86 && i < 400) begin
            en4 = ((i % 7) != 5);
            tick();
            if (en4) e++;
            i++;
            check("div4_count", 16'(count4), pingpong(e / 4));
        end
        check("div4_reached_9_down", 16'(count4), 16'h0009);

        // Reset with prescaler mid-count while going down.
        en4 = 1'b1;
        reset4 = 1'b0;
        tick();
        check("div4_midreset_count", 16'(count4), 16'h0000);
        reset4 = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("div4_after_reset", 16'(count4), 16'(j / 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
